lenet_frame_buffer: RTL and testbench

LENET_FRAME_BUFFER -- requirements
Module: lenet_frame_buffer

---
 rtl/lenet_frame_buffer_if.sv | 31 +++
 rtl/lenet_frame_buffer.sv | 118 +++++++++++
 tb/tb_lenet_frame_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lenet_frame_buffer_if.sv
// Pixel-stream in, random-access read out for the LeNet input frame buffer.
// slave is the buffer side, master is the producer/consumer side.
interface lenet_frame_buffer_if #(
  parameter int PIX_BITS = 8,
  parameter int AW       = 10
);
  logic                       in_start;
  logic                       in_v;
  logic signed [PIX_BITS-1:0] in_pix;
  logic                       rd_en;
  logic [AW-1:0]              rd_addr;
  logic signed [PIX_BITS-1:0] rd_data;
  logic                       frame_ready;
  logic                       frame_done;
  logic [7:0]                 drop_cnt;
  logic                       err_short;

  modport slave (
    input  in_start, in_v, in_pix,
    input  rd_en, rd_addr, frame_done,
    output rd_data, frame_ready,
    output drop_cnt, err_short
  );

  modport master (
    output in_start, in_v, in_pix,
    output rd_en, rd_addr, frame_done,
    input  rd_data, frame_ready,
    input  drop_cnt, err_short
  );
endinterface

// File: rtl/lenet_frame_buffer.sv
// Ping-pong frame buffer between the pixel stream and the conv1 engine.
// One bank fills while the other is read; frames with no free bank are dropped.
module lenet_frame_buffer #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int PIX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  lenet_frame_buffer_if.slave  bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam logic [AW:0] LAST = (AW+1)'(N - 1);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;

  logic [PIX_BITS-1:0] mem0 [N];
  logic [PIX_BITS-1:0] mem1 [N];

  wstate_t       state_q, state_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic [7:0]    drop_q, drop_d;
  logic          err_q, err_d;
  logic [PIX_BITS-1:0] rd_q;

  logic          we;
  logic [AW-1:0] waddr;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    drop_d    = drop_q;
    err_d     = err_q;
    we        = 1'b0;
    waddr     = wr_cnt_q[AW-1:0];
    unique case (state_q)
      W_IDLE: begin
        if (bus.in_start && bus.in_v) begin
          if (!full_q[wr_bank_q]) begin
            we       = 1'b1;
            waddr    = '0;
            wr_cnt_d = (AW+1)'(1);
            state_d  = W_FILL;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      W_FILL: begin
        if (bus.in_v) begin
          we = 1'b1;
          if (bus.in_start) begin
            // restart the same bank; the short frame is discarded
            err_d    = 1'b1;
            waddr    = '0;
            wr_cnt_d = (AW+1)'(1);
          end else if (wr_cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            wr_cnt_d  = '0;
            state_d   = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + (AW+1)'(1);
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
    // the filling bank is never full, so this never touches the bit set above
    if (bus.frame_done && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= W_IDLE;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      drop_q    <= 8'd0;
      err_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      if (bus.rd_en) begin
        rd_q <= rd_bank_q ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !srst) begin
      if (wr_bank_q) mem1[waddr] <= bus.in_pix;
      else           mem0[waddr] <= bus.in_pix;
    end
  end

  assign bus.rd_data     = rd_q;
  assign bus.frame_ready = full_q[rd_bank_q];
  assign bus.drop_cnt    = drop_q;
  assign bus.err_short   = err_q;
endmodule

// File: tb/tb_lenet_frame_buffer.sv
// Directed bench for lenet_frame_buffer: fill, ping-pong, drop,
// short frame, gapped input with reset, and coincident done/complete.
module tb_lenet_frame_buffer;
  logic clk = 1'b0;
  logic srst;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  lenet_frame_buffer_if #(.PIX_BITS(8), .AW(10)) bus ();

  lenet_frame_buffer #(
    .IMG_W(32), .IMG_H(32), .PIX_BITS(8)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic st, input logic [7:0] pix, input logic done);
    bus.in_v       = 1'b1;
    bus.in_start   = st;
    bus.in_pix     = pix;
    bus.frame_done = done;
    tick();
    bus.in_v       = 1'b0;
    bus.in_start   = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  // mode 0: pixel i = i mod 128; mode 1: constant val
  task automatic send_frame(input int mode, input logic [7:0] val,
                            input int n, input int gap);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = (mode == 0) ? 8'(i % 128) : val;
      send_pix(i == 0, p, 1'b0);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic rd(input int addr, output int data);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 10'(addr);
    tick();
    bus.rd_en   = 1'b0;
    data = int'(bus.rd_data);
  endtask

  task automatic done_pulse();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  initial begin
    int d;
    srst = 1'b1;
    bus.in_v = 0; bus.in_start = 0; bus.in_pix = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.frame_done = 0;
    tick(); tick();
    check("rst_ready", bus.frame_ready, 0);
    check("rst_drop", bus.drop_cnt, 0);
    check("rst_err", bus.err_short, 0);
    check("rst_rdata", bus.rd_data, 0);
    srst = 1'b0;

    // done with nothing ready must not move rd_bank
    done_pulse();
    send_frame(0, 8'd0, 1023, 0);
    check("s1_ready_early", bus.frame_ready, 0);
    send_pix(1'b0, 8'd127, 1'b0);
    check("s1_ready", bus.frame_ready, 1);
    rd(37, d);   check("s1_rd37", d, 37);
    rd(1000, d); check("s1_rd1000", d, 104);
    rd(128, d);  check("s1_rd128", d, 0);
    tick(); tick();
    check("s1_hold", bus.rd_data, 0);
    done_pulse();
    check("s1_released", bus.frame_ready, 0);

    // A=5 into bank1, B=-3 into bank0
    send_frame(1, 8'd5, 1024, 0);
    send_frame(1, 8'hFD, 1024, 0);
    check("s2_ready", bus.frame_ready, 1);
    rd(10, d); check("s2_rdA", d, 5);
    send_frame(1, 8'd7, 1024, 0);
    check("s3_drop", bus.drop_cnt, 1);
    rd(10, d); check("s3_rdA_kept", d, 5);
    done_pulse();
    check("s2_ready_after", bus.frame_ready, 1);
    rd(500, d); check("s2_rdB", d, -3);
    send_frame(1, 8'd9, 1024, 0);
    check("s3_drop_same", bus.drop_cnt, 1);
    done_pulse();
    check("s3_ready_D", bus.frame_ready, 1);
    rd(3, d); check("s3_rdD", d, 9);
    done_pulse();
    check("s3_empty", bus.frame_ready, 0);

    // short frame then full frame into bank0
    send_frame(1, 8'h55, 500, 0);
    check("s4_err_pre", bus.err_short, 0);
    send_frame(0, 8'd0, 1024, 0);
    check("s4_err", bus.err_short, 1);
    check("s4_ready", bus.frame_ready, 1);
    rd(0, d);    check("s4_rd0", d, 0);
    rd(1023, d); check("s4_rd1023", d, 127);
    rd(499, d);  check("s4_rd499", d, 115);
    done_pulse();

    // gapped input, reset mid-frame
    send_frame(0, 8'd0, 700, 2);
    srst = 1'b1;
    bus.in_v = 1'b1; bus.in_pix = 8'd1;
    tick();
    srst = 1'b0; bus.in_v = 1'b0;
    check("s5_ready_rst", bus.frame_ready, 0);
    check("s5_err_rst", bus.err_short, 0);
    send_frame(1, 8'h21, 1023, 0);
    check("s5_ready_early", bus.frame_ready, 0);
    send_pix(1'b0, 8'h21, 1'b0);
    check("s5_ready", bus.frame_ready, 1);
    check("s5_drop", bus.drop_cnt, 0);
    rd(5, d); check("s5_rd", d, 33);
    done_pulse();
    check("s5_empty", bus.frame_ready, 0);

    // E into bank1, F into bank0 completing with done on same edge
    send_frame(1, 8'h11, 1024, 0);
    check("s6_readyE", bus.frame_ready, 1);
    send_frame(1, 8'h22, 1023, 0);
    send_pix(1'b0, 8'h22, 1'b1);
    check("s6_ready", bus.frame_ready, 1);
    rd(77, d); check("s6_rdF", d, 34);
    done_pulse();
    check("s6_only_F", bus.frame_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
